// File: rtl/csa_resolve_serial_pkg.sv
// Shared definitions for the serial carry-save resolver and other chunked datapath blocks.
//   state_e  : FSM state encoding (IDLE=0, BUSY=1, DONE=2)
//   ceil_div : ceiling division, used to size chunk counts at elaboration time
package csa_resolve_serial_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/csa_chunk_adder.sv
// Combinational CHUNK-bit adder with carry-in and carry-out.
//   a_i, b_i : operand chunks
//   cin_i    : carry from the previous chunk
//   sum_o    : CHUNK-bit sum
//   cout_o   : carry into the next chunk
module csa_chunk_adder #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o
);

    logic [CHUNK:0] full;

    always_comb begin
        full   = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};
        sum_o  = full[CHUNK-1:0];
        cout_o = full[CHUNK];
    end

endmodule

// File: rtl/csa_resolve_serial.sv
// Resolves a carry-save pair (in_s, in_c) into a binary sum, CHUNK bits per cycle, with the
// carry registered between chunks.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : operand handshake; in_s/in_c latched on acceptance
//   in_s, in_c           : carry-save sum and (pre-aligned) carry vectors, WIDTH bits
//   out_valid/out_ready  : result handshake
//   out_sum              : in_s + in_c, WIDTH+1 bits, held stable while out_valid & !out_ready
module csa_resolve_serial
    import csa_resolve_serial_pkg::*;
#(
    parameter int unsigned WIDTH = 23,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_s,
    input  logic [WIDTH-1:0] in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum
);

    localparam int unsigned NCHUNK = ceil_div(WIDTH, CHUNK);
    localparam int unsigned PW     = NCHUNK * CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    // Position of result bit WIDTH inside the final chunk's {cout, sum}; equals CHUNK (the
    // carry-out) when the last chunk is full, otherwise a sum bit of the zero-extended chunk.
    localparam int unsigned LAST_TOP = WIDTH - (NCHUNK - 1) * CHUNK;

    state_e           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH:0]   res_q, res_d;

    int unsigned      shamt;
    logic [CHUNK-1:0] chunk_a, chunk_b, chunk_sum;
    logic             chunk_cout;
    logic             last_chunk;
    logic [WIDTH-1:0] chunk_mask, chunk_place;

    // Chunk select: operands are zero-extended to a whole number of chunks.
    assign shamt      = 32'(idx_q) * CHUNK;
    assign chunk_a    = CHUNK'(PW'(s_q) >> shamt);
    assign chunk_b    = CHUNK'(PW'(c_q) >> shamt);
    assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));

    csa_chunk_adder #(
        .CHUNK (CHUNK)
    ) u_adder (
        .a_i    (chunk_a),
        .b_i    (chunk_b),
        .cin_i  (carry_q),
        .sum_o  (chunk_sum),
        .cout_o (chunk_cout)
    );

    // Result write-back: positions above WIDTH in a partial final chunk are dropped here.
    assign chunk_mask  = WIDTH'(PW'({CHUNK{1'b1}}) << shamt);
    assign chunk_place = WIDTH'(PW'(chunk_sum) << shamt);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            c_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            c_q     <= c_d;
            res_q   <= res_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid)   state_d = StBusy;
            StBusy:  if (last_chunk) state_d = StDone;
            StDone:  if (out_ready)  state_d = StIdle;
            default:                 state_d = StIdle;
        endcase
    end

    // Datapath next-state
    always_comb begin
        s_d     = s_q;
        c_d     = c_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        res_d   = res_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    s_d     = in_s;
                    c_d     = in_c;
                    carry_d = 1'b0;
                    idx_d   = '0;
                end
            end
            StBusy: begin
                res_d[WIDTH-1:0] = (res_q[WIDTH-1:0] & ~chunk_mask) | chunk_place;
                carry_d          = chunk_cout;
                if (last_chunk) begin
                    res_d[WIDTH] = 1'({chunk_cout, chunk_sum} >> LAST_TOP);
                    idx_d        = '0;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == StIdle) && !rst;
        out_valid = (state_q == StDone);
        out_sum   = res_q;
    end

endmodule
